// File: rtl/demux_1to8_pkg.sv
// -----------------------------------------------------------------------------
// demux_1to8_pkg
// Shared constants and helpers for the 1-to-8 registered demultiplexer.
//   N_OUT   : number of output lanes (fixed at 8)
//   SEL_W   : width of the lane index
//   sel_t   : lane-index type
//   onehot8 : lane index -> 8-bit one-hot code
// -----------------------------------------------------------------------------
package demux_1to8_pkg;

  localparam int N_OUT = 8;
  localparam int SEL_W = 3;

  typedef logic [SEL_W-1:0] sel_t;

  // Full case table so every index has an explicit code and nothing is inferred.
  function automatic logic [N_OUT-1:0] onehot8(input sel_t s);
    logic [N_OUT-1:0] code;
    case (s)
      3'd0:    code = 8'h01;
      3'd1:    code = 8'h02;
      3'd2:    code = 8'h04;
      3'd3:    code = 8'h08;
      3'd4:    code = 8'h10;
      3'd5:    code = 8'h20;
      3'd6:    code = 8'h40;
      3'd7:    code = 8'h80;
      default: code = 8'h00;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/demux_1to8_dec3to8.sv
// -----------------------------------------------------------------------------
// dec3to8
// Purely combinational 3-to-8 one-hot decoder. Its output both gates the data
// lanes and becomes the lane-valid marker in the top level.
// Ports:
//   i_sel    : lane index 0..7
//   o_onehot : one-hot code, bit k set when i_sel == k
// -----------------------------------------------------------------------------
module dec3to8
  import demux_1to8_pkg::*;
(
  input  sel_t             i_sel,
  output logic [N_OUT-1:0] o_onehot
);

  // Decode the lane index.
  always_comb begin
    o_onehot = onehot8(i_sel);
  end

endmodule

// File: rtl/demux_1to8.sv
// -----------------------------------------------------------------------------
// demux_1to8
// Registered 1-to-8 demultiplexer. When enabled, din is routed to lane sel of
// z, every other lane is cleared, and z_vld carries the one-hot code of sel.
// All outputs come straight from flops (1-cycle latency, no input-to-output
// combinational path). Reset is synchronous, active high, and wins over en.
//
// Build option:
//   DEMUX_1TO8_HOLD_EN  defined   -> a disabled cycle holds z / z_vld
//                       undefined -> a disabled cycle clears z / z_vld
//
// Ports:
//   clk   : clock, all state updates on the rising edge
//   rst   : synchronous active-high reset
//   en    : routing enable
//   din   : data to route (DATA_W bits)
//   sel   : destination lane 0..7
//   z     : 8 lanes of DATA_W bits, lane k at [k*DATA_W +: DATA_W]
//   z_vld : one-hot marker of the lane carrying data
// -----------------------------------------------------------------------------
module demux_1to8
  import demux_1to8_pkg::*;
#(
  parameter int DATA_W = 1,
  parameter int N_OUT  = 8
)
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [DATA_W-1:0]       din,
  input  sel_t                    sel,
  output logic [N_OUT*DATA_W-1:0] z,
  output logic [N_OUT-1:0]        z_vld
);

  logic [N_OUT-1:0]        w_onehot;
  logic [N_OUT*DATA_W-1:0] w_lanes;
  logic [N_OUT*DATA_W-1:0] w_z_next;
  logic [N_OUT-1:0]        w_vld_next;
  logic [N_OUT*DATA_W-1:0] r_z;
  logic [N_OUT-1:0]        r_z_vld;

  dec3to8 u_dec (
    .i_sel    (sel),
    .o_onehot (w_onehot)
  );

  // Gate din onto the selected lane; all other lanes are forced to zero so a
  // lane switch clears the old lane on the same edge that loads the new one.
  always_comb begin
    w_lanes = {(N_OUT*DATA_W){1'b0}};
    for (int k = 0; k < N_OUT; k++) begin
      if (w_onehot[k]) begin
        w_lanes[k*DATA_W +: DATA_W] = din;
      end else begin
        w_lanes[k*DATA_W +: DATA_W] = {DATA_W{1'b0}};
      end
    end
  end

  // Next-state selection; the build option only changes the disabled cycle.
  always_comb begin
    w_z_next   = {(N_OUT*DATA_W){1'b0}};
    w_vld_next = {N_OUT{1'b0}};
    if (en) begin
      w_z_next   = w_lanes;
      w_vld_next = w_onehot;
    end else begin
`ifdef DEMUX_1TO8_HOLD_EN
      w_z_next   = r_z;
      w_vld_next = r_z_vld;
`else
      w_z_next   = {(N_OUT*DATA_W){1'b0}};
      w_vld_next = {N_OUT{1'b0}};
`endif
    end
  end

  // Output registers with synchronous reset taking priority over routing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_z     <= {(N_OUT*DATA_W){1'b0}};
      r_z_vld <= {N_OUT{1'b0}};
    end else begin
      r_z     <= w_z_next;
      r_z_vld <= w_vld_next;
    end
  end

  assign z     = r_z;
  assign z_vld = r_z_vld;

endmodule

// File: tb/tb_demux_1to8.sv
// -----------------------------------------------------------------------------
// tb_demux_1to8
// Scoreboard bench for demux_1to8. Two instances (DATA_W=1 and DATA_W=4) share
// clk/rst/en/sel. The driver updates a lane-array model and queues the
// expected outputs; a monitor pops and compares one entry after each edge.
// -----------------------------------------------------------------------------
module tb_demux_1to8;

  typedef struct {
    logic [7:0]  z1;
    logic [31:0] z4;
    logic [7:0]  v;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic [2:0]  sel = 3'd0;
  logic        din1 = 1'b0;
  logic [3:0]  din4 = 4'd0;
  logic [7:0]  z1;
  logic [7:0]  vld1;
  logic [31:0] z4;
  logic [7:0]  vld4;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  // Reference state: one integer per lane plus the index of the marked lane.
  int   lane1 [8];
  int   lane4 [8];
  int   vsel = -1;
  bit   primed = 1'b0;

  demux_1to8 #(.DATA_W(1)) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .din(din1), .sel(sel), .z(z1), .z_vld(vld1)
  );

  demux_1to8 #(.DATA_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .din(din4), .sel(sel), .z(z4), .z_vld(vld4)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic exp_t model_pack();
    exp_t e;
    e.z1 = 8'h00;
    e.z4 = 32'h0;
    for (int k = 0; k < 8; k++) begin
      e.z1 = e.z1 + 8'((lane1[k] % 2) * (2 ** k));
      e.z4 = e.z4 + 32'((lane4[k] % 16) * (2 ** (4 * k)));
    end
    e.v = (vsel >= 0) ? 8'(2 ** vsel) : 8'h00;
    return e;
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < 8; k++) begin
      lane1[k] = 0;
      lane4[k] = 0;
    end
    vsel = -1;
  endfunction

  // Apply one cycle of stimulus at the falling edge and queue its expectation.
  task automatic drive(input bit r, input bit e, input int s, input int d1, input int d4);
    exp_t prev;
    @(negedge clk);
    prev = model_pack();
    rst  = r;
    en   = e;
    sel  = 3'(s);
    din1 = 1'(d1);
    din4 = 4'(d4);
    if (r) begin
      model_clear();
    end else if (e) begin
      model_clear();
      lane1[s] = d1 % 2;
      lane4[s] = d4 % 16;
      vsel     = s;
    end else begin
`ifndef DEMUX_1TO8_HOLD_EN
      model_clear();
`endif
    end
    sb.push_back(model_pack());
    // Outputs must not react to inputs (or rst) between edges.
    #1;
    if (primed) begin
      check("no_comb_z4", z4, prev.z4);
      check("no_comb_vld", {24'h0, vld1}, {24'h0, prev.v});
    end
    primed = 1'b1;
  endtask

  // Monitor: compare one queued expectation just after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("z_w1",   {24'h0, z1},   {24'h0, e.z1});
        check("vld_w1", {24'h0, vld1}, {24'h0, e.v});
        check("z_w4",   z4,            e.z4);
        check("vld_w4", {24'h0, vld4}, {24'h0, e.v});
      end
    end
  end

  initial begin
    int budget;
    model_clear();

    // Reset held two cycles with an active routing request underneath.
    drive(1'b1, 1'b1, 5, 1, 1);
    drive(1'b1, 1'b1, 5, 1, 15);

    // Sweep every lane with din toggling.
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b1, i, (i + 1) % 2, $urandom_range(0, 15));
    end

    // Lane switch 2 -> 6 on consecutive cycles.
    drive(1'b0, 1'b1, 2, 1, 5);
    drive(1'b0, 1'b1, 6, 1, 9);

    // Disable path after lane 3 is loaded.
    drive(1'b0, 1'b1, 3, 1, 7);
    drive(1'b0, 1'b0, 1, 1, 3);

    // Reset beats enable on the same edge, then routing resumes immediately.
    drive(1'b0, 1'b1, 4, 1, 12);
    drive(1'b1, 1'b1, 7, 1, 15);
    drive(1'b0, 1'b1, 0, 1, 1);

    // Wide data on lane 3, and din=0 still marks the lane.
    drive(1'b0, 1'b1, 3, 1, 10);
    drive(1'b0, 1'b1, 5, 0, 0);

    // Randomized traffic with occasional resets and disabled cycles.
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
            $urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 15));
    end

    // Let the monitor drain, bounded.
    budget = 10;
    while (sb.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/demux_1to8.md
DEMUX_1TO8 -- requirements
Module: demux_1to8

Interface
REQ-001 SHALL have parameter DATA_W, default 1, giving the width of din and of each output lane.
REQ-002 SHALL have parameter N_OUT, fixed at 8, giving the output lane count; other values are unsupported.
REQ-003 SHALL use one clock and a synchronous, active-high reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-006 SHALL have port en, input, 1 bit: routing enable.
REQ-007 SHALL have port din, input, DATA_W bits: data to route.
REQ-008 SHALL have port sel, input, 3 bits: destination lane index, 0..7.
REQ-009 SHALL have port z, output, 8*DATA_W bits: lane k occupies bits [k*DATA_W +: DATA_W].
REQ-010 SHALL have port z_vld, output, 8 bits: one-hot marker of the lane currently carrying data.

Function
REQ-011 SHALL register all outputs, so a din/sel/en sample at edge N appears on z/z_vld after edge N, giving 1-cycle latency.
REQ-012 SHALL, on an edge with rst=0 and en=1, load lane sel of z with din, load all other lanes with 0, and set z_vld to the one-hot code of sel.
REQ-013 SHALL, on an edge with rst=0 and en=1, keep z_vld one-hot even when din=0; the value of din SHALL NOT affect z_vld.
REQ-014 SHALL, on an edge with rst=0 and en=0 (macro undefined), set z to all zeros and z_vld to 0.
REQ-015 SHALL, when sel changes between consecutive enabled cycles, clear the previously selected lane on the same edge that loads the new lane; no cycle may have two nonzero lanes.
REQ-016 SHALL give the same response for all sel values 0..7 with no special cases; sel=0 maps to lane 0, the LSB of z.
REQ-017 SHALL contain no combinational path from any input to any output.
REQ-018 SHALL treat X/Z on sel during en=1 as undefined and SHALL NOT require detection of it.

Reset
REQ-019 SHALL, on an edge with rst=1, clear z to 0 and z_vld to 0, regardless of en, sel and din.
REQ-020 SHALL give rst priority over en on the same edge.
REQ-021 SHALL, when reset asserts mid-stream, make the first edge with rst=1 clear the outputs.
REQ-022 SHALL, once rst deasserts, resume normal routing on the first edge with rst=0.
REQ-023 SHALL NOT reset asynchronously; rst SHALL have no effect between clock edges.

Configuration
REQ-024 SHALL use macro DEMUX_1TO8_HOLD_EN to select the disabled-cycle behaviour.
REQ-025 SHALL, with DEMUX_1TO8_HOLD_EN defined, make an edge with en=0 and rst=0 hold z and z_vld at their previous values.
REQ-026 SHALL, with DEMUX_1TO8_HOLD_EN undefined, make an edge with en=0 and rst=0 clear z and z_vld, per REQ-014.
REQ-027 SHALL NOT let the macro alter the reset or enabled-cycle behaviour.

Structure
REQ-028 SHALL place the constants N_OUT=8 and SEL_W=3 in shared package demux_1to8_pkg.
REQ-029 SHALL place the lane-index typedef sel_t (logic [SEL_W-1:0]) and a onehot8(sel_t) function in demux_1to8_pkg.
REQ-030 SHALL instantiate one combinational sub-module, dec3to8, which maps sel to an 8-bit one-hot code and drives both the lane gating and z_vld.
REQ-031 SHALL keep all registers in demux_1to8 itself.

Verification
REQ-032 SHALL check reset: rst=1 for 2 cycles with din=1, sel=5, en=1 -> z=0 and z_vld=0 after each edge.
REQ-033 SHALL check an exhaustive sweep: DATA_W=1, en=1, din toggling every cycle, sel counting 0..7 -> after each edge z = din<<sel and z_vld = 1<<sel, with the checker delayed one cycle.
REQ-034 SHALL check lane switching: sel=2 then sel=6 with din=1 on consecutive cycles -> z=0x04 then z=0x40, never 0x44.
REQ-035 SHALL check the disable path: after z=0x08, drive en=0 for 1 cycle -> z=0x00 and z_vld=0x00 with the macro undefined, z=0x08 held with the macro defined.
REQ-036 SHALL check reset priority: rst=1 and en=1 on the same edge with sel=7, din=1 -> z=0.
REQ-037 SHALL check wide data: DATA_W=4, sel=3, din=0xA -> z = 0xA<<12 and z_vld=0x08.
